// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end for the decode/execute datapath.
// Owns the program counter, drives the instruction-memory address, and
// presents one registered instruction per cycle to decode. It also runs the
// program handshake with the test bench: req starts a program, and ack
// reports that the program is done. A watchdog forces runaway programs to
// finish.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the retired_ct output.
// retired_ct is a saturating count of accepted instructions.
module fetch_unit #(
  parameter int              PW     = 10,
  parameter int              IW     = 9,
  parameter int              WDW    = 16,
  parameter logic [WDW-1:0]  MAXCYC = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [PW-1:0] prog_base,
  output logic [PW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  input  logic          stall,
  input  logic          branch_en,
  input  logic [PW-1:0] branch_tgt,
  input  logic          halt,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  output logic [PW-1:0] pc,
  output logic          ack,
  output logic          timeout
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]   retired_ct
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t         state;
  logic [WDW-1:0] wd_count;
  logic           wd_expired;

  // The watchdog fires on the last permitted RUN cycle. That cycle is the
  // MAXCYC-th edge after RUN is entered.
  assign wd_expired = (wd_count == (MAXCYC - WDW'(1)));

  // The memory address follows the PC in every state.
  assign imem_addr = pc;

  // Fetch control FSM. State, PC, the instruction register and the
  // handshake flags all update here. The events are tested in priority
  // order: reset, req, halt, watchdog, branch, stall, then normal advance.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register sees the pre-edge values of the others. Blocking assignments
    // would make the result depend on statement order.
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      ack         <= 1'b0;
      timeout     <= 1'b0;
      wd_count    <= '0;
    end else if (req) begin
      // req restarts the program from any state. If req is held high, the
      // program restarts on every cycle.
      state       <= RUN;
      pc          <= prog_base;
      instr_valid <= 1'b0;
      ack         <= 1'b0;
      timeout     <= 1'b0;
      wd_count    <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (halt) begin
            // pc already points one past the halt instruction, so it holds.
            state       <= HALTED;
            ack         <= 1'b1;
            instr_valid <= 1'b0;
          end else if (wd_expired) begin
            state       <= HALTED;
            ack         <= 1'b1;
            timeout     <= 1'b1;
            instr_valid <= 1'b0;
          end else begin
            // The watchdog counts every RUN cycle, including stalled ones.
            wd_count <= wd_count + WDW'(1);
            if (branch_en) begin
              // Drop the wrong-path fetch. This leaves a one-cycle bubble.
              pc          <= branch_tgt;
              instr_valid <= 1'b0;
            end else if (!stall) begin
              instr       <= imem_data;
              instr_valid <= 1'b1;
              pc          <= pc + PW'(1);
            end
          end
        end
        HALTED: begin
          // ack, timeout and pc hold until the next req.
          state <= HALTED;
        end
        default: begin
          // IDLE: everything holds until the first req.
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Count accepted instructions. An instruction is accepted in a RUN cycle
  // when it is live and not stalled. The count saturates at 16'hFFFF and
  // holds after halt, so the bench can read it once ack is set.
  always_ff @(posedge clk) begin
    if (reset || req) begin
      retired_ct <= '0;
    end else if (state == RUN && instr_valid && !stall &&
                 retired_ct != 16'hFFFF) begin
      retired_ct <= retired_ct + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit.
// The instruction memory returns addr[8:0]. The watchdog limit is 20 cycles.
// Each vector gives the inputs for one cycle and the outputs expected just
// after the following rising edge.
module tb_fetch_unit;

  localparam int PW = 10;
  localparam int IW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic [PW-1:0] prog_base;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          stall;
  logic          branch_en;
  logic [PW-1:0] branch_tgt;
  logic          halt;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic [PW-1:0] pc;
  logic          ack;
  logic          timeout;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]   retired_ct;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // The instruction memory model returns the low 9 bits of the address.
  assign imem_data = imem_addr[IW-1:0];

  fetch_unit #(.PW(PW), .IW(IW), .WDW(16), .MAXCYC(16'd20)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .prog_base  (prog_base),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .stall      (stall),
    .branch_en  (branch_en),
    .branch_tgt (branch_tgt),
    .halt       (halt),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .ack        (ack),
    .timeout    (timeout)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retired_ct (retired_ct)
`endif
  );

  typedef struct {
    logic          req;
    logic [PW-1:0] base;
    logic          stall;
    logic          br;
    logic [PW-1:0] tgt;
    logic          halt;
    logic [PW-1:0] e_pc;
    logic [IW-1:0] e_instr;
    logic          e_v;
    logic          e_ack;
    logic          e_to;
    logic [15:0]   e_rc;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 1'b0; stall = 1'b0; branch_en = 1'b0; halt = 1'b0;
    branch_tgt = '0;
  endtask

  initial begin
    // Straight-line program from 0x020. halt is raised while instr=0x025.
    vecs[0]  = '{1'b1, 10'h020, 1'b0, 1'b0, 10'h000, 1'b0, 10'h020, 9'h000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h021, 9'h020, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h022, 9'h021, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[3]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h023, 9'h022, 1'b1, 1'b0, 1'b0, 16'd2};
    vecs[4]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h024, 9'h023, 1'b1, 1'b0, 1'b0, 16'd3};
    vecs[5]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h025, 9'h024, 1'b1, 1'b0, 1'b0, 16'd4};
    vecs[6]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h026, 9'h025, 1'b1, 1'b0, 1'b0, 16'd5};
    vecs[7]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 10'h026, 9'h025, 1'b0, 1'b1, 1'b0, 16'd6};
    vecs[8]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h026, 9'h025, 1'b0, 1'b1, 1'b0, 16'd6};
    // Stall for 3 cycles at pc=0x030, then branch together with stall.
    vecs[9]  = '{1'b1, 10'h02E, 1'b0, 1'b0, 10'h000, 1'b0, 10'h02E, 9'h025, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[10] = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h02F, 9'h02E, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[11] = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h030, 9'h02F, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[12] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b0, 10'h030, 9'h02F, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[13] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b0, 10'h030, 9'h02F, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[14] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b0, 10'h030, 9'h02F, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[15] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h100, 1'b0, 10'h100, 9'h02F, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[16] = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h101, 9'h100, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[17] = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 10'h101, 9'h100, 1'b0, 1'b1, 1'b0, 16'd2};
    // PC wraps from 0x3FF to 0x000.
    vecs[18] = '{1'b1, 10'h3FE, 1'b0, 1'b0, 10'h000, 1'b0, 10'h3FE, 9'h100, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[19] = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h3FF, 9'h1FE, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[20] = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 9'h1FF, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[21] = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h001, 9'h000, 1'b1, 1'b0, 1'b0, 16'd2};
    vecs[22] = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 10'h001, 9'h000, 1'b0, 1'b1, 1'b0, 16'd3};

    // Reset, then check the reset values and that IDLE holds them.
    idle_inputs();
    prog_base = '0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step(); step();
    check("reset_pc", 32'(pc), 32'h0);
    check("reset_instr", 32'(instr), 32'h0);
    check("reset_valid", 32'(instr_valid), 32'h0);
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_timeout", 32'(timeout), 32'h0);
    check("reset_imem_addr", 32'(imem_addr), 32'h0);

    // Apply the table.
    for (int i = 0; i < 23; i++) begin
      req = vecs[i].req; prog_base = vecs[i].base; stall = vecs[i].stall;
      branch_en = vecs[i].br; branch_tgt = vecs[i].tgt; halt = vecs[i].halt;
      step();
      check($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].e_pc));
      check($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(vecs[i].e_pc));
      check($sformatf("vec%0d_instr", i), 32'(instr), 32'(vecs[i].e_instr));
      check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_v));
      check($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].e_ack));
      check($sformatf("vec%0d_timeout", i), 32'(timeout), 32'(vecs[i].e_to));
`ifdef FETCH_PERF_CNT_EN
      check($sformatf("vec%0d_retired", i), 32'(retired_ct), 32'(vecs[i].e_rc));
`endif
    end
    idle_inputs();

    // Watchdog: ack and timeout rise exactly 20 edges after the req edge.
    req = 1'b1; prog_base = 10'h200;
    step();
    req = 1'b0;
    check("wd_start_pc", 32'(pc), 32'h200);
    for (int k = 1; k < 20; k++) begin
      step();
      check($sformatf("wd_no_ack_%0d", k), 32'(ack), 32'h0);
    end
    step();
    check("wd_ack", 32'(ack), 32'h1);
    check("wd_timeout", 32'(timeout), 32'h1);
    check("wd_valid", 32'(instr_valid), 32'h0);
    check("wd_pc", 32'(pc), 32'h213);
    step();
    check("wd_hold_timeout", 32'(timeout), 32'h1);
    req = 1'b1; prog_base = 10'h000;
    step();
    req = 1'b0;
    check("wd_req_ack_clr", 32'(ack), 32'h0);
    check("wd_req_to_clr", 32'(timeout), 32'h0);
    check("wd_req_pc", 32'(pc), 32'h000);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_after_req_ack", 32'(ack), 32'h1);
    check("halt_after_req_to", 32'(timeout), 32'h0);

    // req during RUN at pc=0x050, then halt and branch together.
    req = 1'b1; prog_base = 10'h04E;
    step();
    req = 1'b0;
    step(); step();
    check("sim_pc_050", 32'(pc), 32'h050);
    req = 1'b1; prog_base = 10'h060;
    step();
    req = 1'b0;
    check("rerun_pc", 32'(pc), 32'h060);
    check("rerun_valid", 32'(instr_valid), 32'h0);
    step();
    check("rerun_instr", 32'(instr), 32'h060);
    check("rerun_valid2", 32'(instr_valid), 32'h1);
    halt = 1'b1; branch_en = 1'b1; branch_tgt = 10'h123;
    step();
    idle_inputs();
    check("hb_ack", 32'(ack), 32'h1);
    check("hb_pc", 32'(pc), 32'h061);
    check("hb_valid", 32'(instr_valid), 32'h0);

    // Reset at pc=0x044 in the middle of a run.
    req = 1'b1; prog_base = 10'h042;
    step();
    req = 1'b0;
    step(); step();
    check("mr_pc_044", 32'(pc), 32'h044);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mr_pc", 32'(pc), 32'h0);
    check("mr_instr", 32'(instr), 32'h0);
    check("mr_valid", 32'(instr_valid), 32'h0);
    check("mr_ack", 32'(ack), 32'h0);
    step(); step(); step();
    check("mr_idle_pc", 32'(pc), 32'h0);
    check("mr_idle_valid", 32'(instr_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
